// File: rtl/fractal_pkg.sv
// rtl/fractal_pkg.sv - shared fixed-point widths, limits and solver state type for the Mandelbrot engine
package fractal_pkg;
    localparam int FIXED_W   = 27;
    localparam int FRAC_BITS = 20;
    localparam int ITER_W    = 8;
    localparam int BUF_DEPTH = 1024;
    localparam int ADDR_W    = 10;
    localparam int PROD_W    = 2 * FIXED_W;
    localparam int MAG_W     = 36;
    localparam int ID_W      = 6;
    localparam int ID_SPACE  = 64;

    localparam logic signed [MAG_W-1:0] ESCAPE_LIMIT = 36'sh000400000;

    typedef logic signed [FIXED_W-1:0] fixed_t;
    typedef logic signed [PROD_W-1:0]  prod_t;
    typedef logic signed [MAG_W-1:0]   mag_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } solver_state_t;
endpackage

// File: rtl/escape_solver.sv
// rtl/escape_solver.sv - one escape-time iteration unit with its private result buffer
module escape_solver
    import fractal_pkg::*;
#(
    parameter int MAX_ITER = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  fixed_t            start_cr,
    input  fixed_t            start_ci,
    output logic              idle,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ITER_W-1:0] rd_data
);
    solver_state_t state, state_next;
    fixed_t cr, ci, zr, zi;
    logic [ITER_W-1:0] iter;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ITER_W-1:0] mem [BUF_DEPTH];

    prod_t zr_sq, zi_sq, zr_zi;
    mag_t  zr2, zi2, mag;
    fixed_t zr_next, zi_next;
    logic escape, finish;

    assign zr_sq = prod_t'(zr) * prod_t'(zr);
    assign zi_sq = prod_t'(zi) * prod_t'(zi);
    assign zr_zi = prod_t'(zr) * prod_t'(zi);
    // Squares are non-negative and below 2^34 after the shift, so the sum never wraps in MAG_W bits.
    assign zr2 = mag_t'(zr_sq >>> FRAC_BITS);
    assign zi2 = mag_t'(zi_sq >>> FRAC_BITS);
    assign mag = zr2 + zi2;
    assign escape = mag > ESCAPE_LIMIT;
    assign zr_next = fixed_t'(zr2 - zi2 + mag_t'(cr));
    assign zi_next = fixed_t'((zr_zi >>> (FRAC_BITS - 1)) + prod_t'(ci));

    assign idle = (state == S_IDLE);

    always_comb begin
        state_next = state;
        finish     = 1'b0;
        case (state)
            S_IDLE: if (start) state_next = S_RUN;
            S_RUN: begin
                if (escape || iter == ITER_W'(MAX_ITER)) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            iter   <= '0;
            cr     <= '0;
            ci     <= '0;
            zr     <= '0;
            zi     <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && start) begin
                cr   <= start_cr;
                ci   <= start_ci;
                zr   <= '0;
                zi   <= '0;
                iter <= '0;
            end else if (state == S_RUN) begin
                if (finish) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end else begin
                    zr   <= zr_next;
                    zi   <= zi_next;
                    iter <= iter + 1'b1;
                end
            end
        end
    end

    // Buffer survives reset; a result completing in a reset cycle is dropped.
    always_ff @(posedge clock) begin
        if (finish && !reset) mem[wr_ptr] <= iter;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/multi_solver.sv
// rtl/multi_solver.sv - grid scanner dispatching points to parallel escape solvers with a registered readback mux
module multi_solver
    import fractal_pkg::*;
#(
    parameter int NUM_SOLVERS = 10,
    parameter int MAX_ITER    = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  fixed_t            min_x,
    input  fixed_t            min_y,
    input  fixed_t            max_x,
    input  fixed_t            max_y,
    input  fixed_t            dx,
    input  fixed_t            dy,
    input  logic [ID_W-1:0]   rd_solver_id,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ITER_W-1:0] rd_data,
    output logic              done
);
    fixed_t cur_x, cur_y, next_x, next_y;
    logic scan_done, any_idle, dispatch;
    logic [ID_W-1:0] pick;
    logic [NUM_SOLVERS-1:0] idle, start;
    logic [ITER_W-1:0] bank_data [ID_SPACE];

    // Downward scan leaves the lowest-index idle solver as the final pick.
    always_comb begin
        any_idle = 1'b0;
        pick     = '0;
        for (int i = NUM_SOLVERS - 1; i >= 0; i--) begin
            if (idle[i]) begin
                any_idle = 1'b1;
                pick     = ID_W'(i);
            end
        end
    end

    assign dispatch = any_idle && !scan_done;

    always_comb begin
        start = '0;
        for (int i = 0; i < NUM_SOLVERS; i++) begin
            start[i] = dispatch && (pick == ID_W'(i));
        end
    end

    assign next_x = cur_x + dx;
    assign next_y = cur_y + dy;

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_x     <= min_x;
            cur_y     <= min_y;
            scan_done <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (dispatch) begin
                if (next_x > max_x) begin
                    cur_x <= min_x;
                    cur_y <= next_y;
                    if (next_y > max_y) scan_done <= 1'b1;
                end else begin
                    cur_x <= next_x;
                end
            end
            if (scan_done && (&idle)) done <= 1'b1;
        end
    end

    // Unpopulated IDs read as zero so the mux needs no range check.
    for (genvar g = 0; g < ID_SPACE; g++) begin : g_bank
        if (g < NUM_SOLVERS) begin : g_solver
            escape_solver #(.MAX_ITER(MAX_ITER)) u_solver (
                .clock    (clock),
                .reset    (reset),
                .start    (start[g]),
                .start_cr (cur_x),
                .start_ci (cur_y),
                .idle     (idle[g]),
                .rd_addr  (rd_addr),
                .rd_data  (bank_data[g])
            );
        end else begin : g_empty
            assign bank_data[g] = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= bank_data[rd_solver_id];
        end
    end
endmodule

// File: tb/tb_multi_solver.sv
// tb/tb_multi_solver.sv - self-checking bench for multi_solver against an event-level Mandelbrot model
module tb_multi_solver;
    localparam int MAX_ITER = 255;
    localparam longint ONE = 64'sd1048576;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic reset1 = 1'b1;
    logic signed [26:0] min_x = '0, min_y = '0, max_x = '0, max_y = '0, dx = '0, dy = '0;
    logic [5:0] rd_solver_id = '0, rd_solver_id1 = '0;
    logic [9:0] rd_addr = '0, rd_addr1 = '0;
    logic [7:0] rd_data, rd_data1;
    logic done, done1;

    multi_solver #(.NUM_SOLVERS(10), .MAX_ITER(MAX_ITER)) dut (
        .clock(clock), .reset(reset), .min_x(min_x), .min_y(min_y), .max_x(max_x), .max_y(max_y),
        .dx(dx), .dy(dy), .rd_solver_id(rd_solver_id), .rd_addr(rd_addr), .rd_data(rd_data), .done(done)
    );

    multi_solver #(.NUM_SOLVERS(1), .MAX_ITER(MAX_ITER)) dut1 (
        .clock(clock), .reset(reset1), .min_x(min_x), .min_y(min_y), .max_x(max_x), .max_y(max_y),
        .dx(dx), .dy(dy), .rd_solver_id(rd_solver_id1), .rd_addr(rd_addr1), .rd_data(rd_data1), .done(done1)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    int exp_val [64][1024];
    int exp_wcyc [64][1024];
    int m_wcount [64];
    longint m_done_cycle;

    typedef struct {
        longint cx;
        longint cy;
        int     exp_count;
        int     exp_done;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrap27(input longint v);
        return (v <<< 37) >>> 37;
    endfunction

    function automatic int model_count(input longint cx, input longint cy);
        longint zr = 0, zi = 0, zr2, zi2, nzr;
        for (int it = 0; it < MAX_ITER; it++) begin
            zr2 = (zr * zr) >>> 20;
            zi2 = (zi * zi) >>> 20;
            if (zr2 + zi2 > 4 * ONE) return it;
            nzr = wrap27(zr2 - zi2 + cx);
            zi  = wrap27(((zr * zi) >>> 19) + cy);
            zr  = nzr;
        end
        return MAX_ITER;
    endfunction

    // Each point goes at cycle t to the lowest solver free at t; it runs count+1 cycles then idles.
    task automatic model_scan(input longint mnx, input longint mny, input longint mxx, input longint mxy,
                              input longint sdx, input longint sdy, input int nsolv, input int tlimit);
        longint free_at [64];
        longint x = mnx, y = mny, t = 0, maxfree = 0;
        int s, res, a;
        for (int i = 0; i < 64; i++) begin
            free_at[i] = 0;
            m_wcount[i] = 0;
            for (int j = 0; j < 1024; j++) begin
                exp_val[i][j] = -1;
                exp_wcyc[i][j] = -1;
            end
        end
        while (y <= mxy && t < tlimit) begin
            s = -1;
            for (int i = nsolv - 1; i >= 0; i--) if (free_at[i] <= t) s = i;
            if (s >= 0) begin
                res = model_count(x, y);
                a = m_wcount[s] % 1024;
                exp_val[s][a] = res;
                exp_wcyc[s][a] = int'(t) + res + 1;
                m_wcount[s]++;
                free_at[s] = t + res + 2;
                if (free_at[s] > maxfree) maxfree = free_at[s];
                x += sdx;
                if (x > mxx) begin
                    x = mnx;
                    y += sdy;
                end
            end
            t++;
        end
        m_done_cycle = maxfree + 1;
    endtask

    task automatic start_scan(input longint mnx, input longint mny, input longint mxx, input longint mxy,
                              input longint sdx, input longint sdy, input bit unit1);
        @(negedge clock);
        min_x = 27'(mnx); min_y = 27'(mny); max_x = 27'(mxx); max_y = 27'(mxy);
        dx = 27'(sdx); dy = 27'(sdy);
        if (unit1) reset1 = 1'b1; else reset = 1'b1;
        @(negedge clock);
        if (unit1) reset1 = 1'b0; else reset = 1'b0;
    endtask

    task automatic wait_done(input bit unit1, input int limit, output int n);
        n = 0;
        while (!(unit1 ? done1 : done) && n < limit) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic read0(input int sid, input int addr, output int v);
        rd_solver_id = 6'(sid);
        rd_addr = 10'(addr);
        @(negedge clock);
        v = int'(rd_data);
    endtask

    task automatic read1(input int sid, input int addr, output int v);
        rd_solver_id1 = 6'(sid);
        rd_addr1 = 10'(addr);
        @(negedge clock);
        v = int'(rd_data1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, v, grid_s1, prev_exp;
        int tgt_s [3];
        int tgt_a [3];

        tbl[0] = '{-2 * ONE, -ONE, 1, 4};
        tbl[1] = '{0, 0, 255, 258};
        tbl[2] = '{ONE, 0, 3, 6};
        tbl[3] = '{2 * ONE, 0, 2, 5};
        tbl[4] = '{0, 2 * ONE, 2, 5};
        tbl[5] = '{-2 * ONE, 0, 255, 258};

        repeat (3) @(negedge clock);
        check("reset_rd_data", rd_data, 0);
        check("reset_done", done, 0);

        // 4x3 grid on ten solvers
        model_scan(-2 * ONE, -ONE, ONE, ONE, ONE, ONE, 10, 100000);
        start_scan(-2 * ONE, -ONE, ONE, ONE, ONE, ONE, 0);
        wait_done(0, 2000, n);
        check("grid_done_cycle", n, m_done_cycle);
        for (int s = 0; s < 10; s++) begin
            for (int a = 0; a < 4; a++) begin
                if (exp_val[s][a] >= 0) begin
                    read0(s, a, v);
                    check($sformatf("grid_s%0d_a%0d", s, a), v, exp_val[s][a]);
                end
            end
        end
        grid_s1 = exp_val[1][0];
        read0(10, 0, v);
        check("invalid_id10", v, 0);
        read0(63, 0, v);
        check("invalid_id63", v, 0);

        // single-point windows
        for (int i = 0; i < 6; i++) begin
            start_scan(tbl[i].cx, tbl[i].cy, tbl[i].cx, tbl[i].cy, ONE, ONE, 0);
            wait_done(0, 1000, n);
            check($sformatf("pt%0d_done_cycle", i), n, tbl[i].exp_done);
            read0(0, 0, v);
            check($sformatf("pt%0d_count", i), v, tbl[i].exp_count);
            read0(1, 0, v);
            check($sformatf("pt%0d_s1_untouched", i), v, grid_s1);
            check($sformatf("pt%0d_done_sticky", i), done, 1);
        end

        // large grid, partial run
        model_scan(-2 * ONE, -ONE, ONE, ONE, 1638, 2185, 10, 4000);
        start_scan(-2 * ONE, -ONE, ONE, ONE, 1638, 2185, 0);
        repeat (3900) @(negedge clock);
        check("full_done_low", done, 0);
        tgt_s = '{0, 0, 1};
        tgt_a = '{17, 140, 140};
        prev_exp = 0;
        for (int j = 0; j < 3; j++) begin
            if (exp_wcyc[tgt_s[j]][tgt_a[j]] < 0 || exp_wcyc[tgt_s[j]][tgt_a[j]] > 3890) begin
                for (int a = 0; a < 1024; a++) begin
                    if (exp_wcyc[tgt_s[j]][a] >= 0 && exp_wcyc[tgt_s[j]][a] <= 3890) tgt_a[j] = a;
                end
            end
            rd_solver_id = 6'(tgt_s[j]);
            rd_addr = 10'(tgt_a[j]);
            #1;
            if (j > 0) check($sformatf("full_hold%0d", j), rd_data, prev_exp);
            @(negedge clock);
            check($sformatf("full_s%0d_a%0d", tgt_s[j], tgt_a[j]), rd_data, exp_val[tgt_s[j]][tgt_a[j]]);
            prev_exp = exp_val[tgt_s[j]][tgt_a[j]];
        end

        // one-cycle reset in the middle of the scan
        reset = 1'b1;
        @(negedge clock);
        check("midreset_rd_data", rd_data, 0);
        check("midreset_done", done, 0);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        read0(0, 0, v);
        check("midreset_s0_a0", v, 1);
        check("midreset_done_low", done, 0);
        start_scan(0, 0, 0, 0, ONE, ONE, 0);
        wait_done(0, 1000, n);
        check("ptr_reset_done_cycle", n, 258);
        read0(0, 0, v);
        check("ptr_reset_s0_a0", v, 255);

        // single-solver wrap: 1025 points in one column
        reset = 1'b1;
        model_scan(ONE, 0, ONE, 2 * ONE, ONE, 2048, 1, 100000);
        start_scan(ONE, 0, ONE, 2 * ONE, ONE, 2048, 1);
        wait_done(1, 20000, n);
        check("wrap_done_cycle", n, m_done_cycle);
        read1(0, 0, v);
        check("wrap_a0", v, exp_val[0][0]);
        read1(0, 1, v);
        check("wrap_a1", v, exp_val[0][1]);
        read1(0, 1023, v);
        check("wrap_a1023", v, exp_val[0][1023]);
        read1(63, 0, v);
        check("wrap_id63", v, 0);
        read1(1, 0, v);
        check("wrap_id1", v, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
